deadlock_report_ctrl: RTL

DEADLOCK_REPORT_CTRL -- requirements
Module: deadlock_report_ctrl

---
 rtl/dl_pkg.sv | 21 ++
 rtl/dl_prio_onehot.sv | 11 +
 rtl/deadlock_report_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dl_pkg.sv
// Shared types for the deadlock report controller.
// DL_CONFIRM_EN adds the CONFIRM persistence state.
package dl_pkg;

   localparam int unsigned DL_COUNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REPORT  = 2'd1,
      ST_CLEAR   = 2'd2
`ifdef DL_CONFIRM_EN
      ,
      ST_CONFIRM = 2'd3
`endif
   } dl_state_e;

   function automatic logic [DL_COUNT_W-1:0] sat_inc(input logic [DL_COUNT_W-1:0] v);
      return (v == '1) ? v : v + DL_COUNT_W'(1);
   endfunction

endpackage

// File: rtl/dl_prio_onehot.sv
// Lowest-index one-hot priority encoder: the lowest set bit of vec_i survives.
module dl_prio_onehot #(
   parameter int unsigned N_PROC = 4
) (
   input  logic [N_PROC-1:0] vec_i,
   output logic [N_PROC-1:0] onehot_o
);

   always_comb onehot_o = vec_i & (~vec_i + N_PROC'(1));

endmodule

// File: rtl/deadlock_report_ctrl.sv
// Deadlock report controller: selects an origin process, reports, then pulses token_clear.
// Optional macro DL_CONFIRM_EN inserts a CONFIRM_CYCLES persistence filter before REPORT.
module deadlock_report_ctrl
   import dl_pkg::*;
#(
   parameter int unsigned N_PROC         = 4,
   parameter int unsigned CONFIRM_CYCLES = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_PROC-1:0]     dl_in_vec,
   input  logic                  clear_req,
   output logic                  dl_detect_out,
   output logic [N_PROC-1:0]     origin,
   output logic                  token_clear,
   output logic [DL_COUNT_W-1:0] dl_count
);

   if (CONFIRM_CYCLES < 1 || CONFIRM_CYCLES > 255) begin : g_bad_cfg
      $error("CONFIRM_CYCLES must be in 1..255");
   end

   dl_state_e               state_q, state_d;
   logic [N_PROC-1:0]       origin_q, origin_d;
   logic                    detect_q, detect_d;
   logic                    tclr_q, tclr_d;
   logic [DL_COUNT_W-1:0]   count_q, count_d;
   logic [N_PROC-1:0]       sel_onehot;

`ifdef DL_CONFIRM_EN
   localparam logic [7:0] CNT_LAST = 8'(CONFIRM_CYCLES - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       origin_hit;
   always_comb origin_hit = |(dl_in_vec & origin_q);
`endif

   dl_prio_onehot #(.N_PROC(N_PROC)) u_prio (
      .vec_i    (dl_in_vec),
      .onehot_o (sel_onehot)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         origin_q <= '0;
         detect_q <= 1'b0;
         tclr_q   <= 1'b0;
         count_q  <= '0;
`ifdef DL_CONFIRM_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         origin_q <= origin_d;
         detect_q <= detect_d;
         tclr_q   <= tclr_d;
         count_q  <= count_d;
`ifdef DL_CONFIRM_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   // Outputs are computed as next-state values so every port comes straight from a flop.
   always_comb begin
      state_d  = state_q;
      origin_d = origin_q;
      detect_d = detect_q;
      tclr_d   = 1'b0;
      count_d  = count_q;
`ifdef DL_CONFIRM_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|dl_in_vec) begin
               origin_d = sel_onehot;
`ifdef DL_CONFIRM_EN
               state_d  = ST_CONFIRM;
               cnt_d    = '0;
`else
               state_d  = ST_REPORT;
               detect_d = 1'b1;
               count_d  = sat_inc(count_q);
`endif
            end
         end
`ifdef DL_CONFIRM_EN
         ST_CONFIRM: begin
            if (clear_req || !origin_hit) begin
               state_d  = ST_CLEAR;
               tclr_d   = 1'b1;
               origin_d = '0;
               detect_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = ST_REPORT;
               detect_d = 1'b1;
               count_d  = sat_inc(count_q);
            end else begin
               cnt_d    = cnt_q + 8'd1;
            end
         end
`endif
         ST_REPORT: begin
            if (clear_req) begin
               state_d  = ST_CLEAR;
               tclr_d   = 1'b1;
               origin_d = '0;
               detect_d = 1'b0;
            end
         end
         ST_CLEAR: state_d = ST_IDLE;
         default: begin
            state_d  = ST_IDLE;
            origin_d = '0;
            detect_d = 1'b0;
         end
      endcase
   end

   assign dl_detect_out = detect_q;
   assign origin        = origin_q;
   assign token_clear   = tclr_q;
   assign dl_count      = count_q;

endmodule
